servant_uart: RTL and testbench
===============================

# servant_uart

Write-only-data UART transmitter peripheral for the servant SoC. It occupies one Wishbone slave slot behind the servant address mux and consumes that slot's `dat`/`we`/`cyc` outputs. The mux supplies no address bits and generates the ack itself, so this block never stalls the bus. Bytes written by the CPU go into a small FIFO and are serialised 8N1 on `o_uart_tx` with a programmable bit period.

## Interface
- `FIFO_AW`, default 4: FIFO depth is 2^FIFO_AW entries.
- `DEFAULT_DIV`, default 139: bit period in clocks after reset (16 MHz / 115200).
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `i_wb_dat`  in  32  write data from the mux.
- `i_wb_we`  in  1  write enable from the mux.
- `i_wb_cyc`  in  1  slot select from the mux, already gated by address decode.
- `o_wb_rdt`  out  32  registered read data (status).
- `o_uart_tx`  out  1  serial output, idle high.

## Operation
- **Access detection.** The mux holds `cyc` high for 2 cycles per access: a request cycle, then the ack cycle. The CPU drops `cyc` for at least 1 cycle between accesses.
  - An access is acted on only in its first cycle: `acc = i_wb_cyc & !cyc_q`, where `cyc_q` is `i_wb_cyc` registered.
- **Write, `acc & we`, `dat[31]=0`.** Push `dat[7:0]` into the FIFO.
  - If the FIFO is full at the start of the cycle, drop the byte and set `ovf`. This holds even if a pop happens in the same cycle.
- **Write, `acc & we`, `dat[31]=1`.** Load `div <= dat[15:0]`. Nothing is pushed.
  - `div` values below 2 are treated as 2.
- **Read, `acc & !we`.** Capture status into `o_wb_rdt` and clear `ovf` at the same edge. The captured value contains the pre-clear `ovf`.
- **Status layout.**
  - [0] busy (FSM not IDLE)
  - [1] full
  - [2] empty
  - [3] ovf
  - [4+FIFO_AW:4] level
  - all other bits 0
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The FIFO entry is popped on this transition, and `div` is latched into `div_l` for the whole frame.
  - START drives 0 for `div_l` clocks, then goes to DATA.
  - DATA drives 8 bits LSB first, `div_l` clocks each. A 3-bit index counts 0..7.
  - STOP drives 1 for `div_l` clocks.
  - When STOP expires: go to START (pop and relatch `div`) if the FIFO is non-empty, otherwise go to IDLE. There is no idle gap between back-to-back frames.
- **Simultaneous push and pop.** Both happen and the level is unchanged.
- **Counter widths.** FIFO pointers are FIFO_AW+1 bits and wrap modulo 2^(FIFO_AW+1). The baud counter is 16 bits and counts down from `div_l-1` to 0.

## Timing
- **Reset values.**
  - `o_uart_tx`=1, `o_wb_rdt`=0, FSM=IDLE.
  - FIFO empty, `ovf`=0, `div`=DEFAULT_DIV, `cyc_q`=0.
- **Reset during a frame.** `o_uart_tx` is 1 in the cycle after reset is sampled. The frame is truncated and FIFO contents are discarded.
- **Push.** The push edge is the request-cycle edge. The level is visible to the next read's capture.
- **Read data.** `o_wb_rdt` is valid from the ack cycle onward and holds until the next read access.
- **Push-to-start latency.** With the FSM idle, the push lands at edge N, START is entered at edge N+1, and `o_uart_tx` falls at edge N+1.
- **Frame length.** 10×`div_l` clocks; 11×`div_l` with parity enabled.
- **Output register.** `o_uart_tx` is registered.

## Configuration
- Macro: `SERVANT_UART_PARITY_EN`.
- **Defined:** a PARITY state is inserted between DATA and STOP. It drives the even parity of the 8 data bits for `div_l` clocks.
- **Undefined:** the PARITY state and its logic are absent, and frames are 8N1.

## Test plan
- **Reset defaults:** assert `i_rst` for 2 cycles, then do one read → `o_wb_rdt`=0x4 and `o_uart_tx`=1 throughout.
- **Single byte:** write `div`=4 (dat 0x8000_0004), then write 0x55 → `o_uart_tx` shows 0 for 4 clocks, then bits 1,0,1,0,1,0,1,0 for 4 clocks each, then 1. Busy=1 during the frame, 0 after.
- **2-cycle cyc:** a write held with `cyc` high for 2 cycles pushes exactly one byte → read level=1 (status 0x10 | busy as applicable).
- **Overflow:** with `div`=100, push 2^FIFO_AW+2 bytes rapidly → one byte is in flight, 16 are queued, one is dropped.
  - First read returns ovf=1 and full=1 (0x10B).
  - Second read returns ovf=0.
- **Back-to-back frames:** push 0xA5 then 0x3C → the second start bit begins the clock after the first stop bit ends.
  - A divider write during frame 1 takes effect at frame 2.
- **Mid-frame reset:** reset during DATA → `o_uart_tx`=1 the next cycle, status reads 0x4, and no further frames are sent.

Source files
------------

// File: rtl/servant_uart.sv
// Write-only UART transmitter: bus writes feed a byte FIFO that is sent as 8N1 with a programmable bit period.
// Optional feature macro SERVANT_UART_PARITY_EN adds an even-parity bit after the data bits.
module servant_uart #(
   parameter int          FIFO_AW     = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd139
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_uart_tx
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
`ifdef SERVANT_UART_PARITY_EN
      ,PARITY = 3'd4
`endif
   } state_t;

   state_t             state_q, state_d;
   logic               cyc_q;
   logic               ovf_q, ovf_d;
   logic [15:0]        div_q, div_d;
   logic [15:0]        div_l_q, div_l_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
   logic               tx_q, tx_d;
   logic [31:0]        rdt_q, rdt_d;
   logic [7:0]         data_q;
   logic [7:0]         mem [DEPTH];

   logic               acc, wr_byte, wr_div, rd_acc;
   logic               full, empty, push, pop, expire;
   logic [FIFO_AW:0]   level;
   logic [15:0]        div_eff;
   logic [31:0]        status;
   logic               unused_dat;

   // The mux holds cyc for two cycles; only the first one is an access.
   assign acc     = i_wb_cyc & ~cyc_q;
   assign wr_byte = acc & i_wb_we & ~i_wb_dat[31];
   assign wr_div  = acc & i_wb_we & i_wb_dat[31];
   assign rd_acc  = acc & ~i_wb_we;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign push    = wr_byte & ~full;
   assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;
   assign expire  = (cnt_q == 16'd0);
   assign unused_dat = ^i_wb_dat[30:16];

   always_comb begin
      status                  = '0;
      status[0]               = (state_q != IDLE);
      status[1]               = full;
      status[2]               = empty;
      status[3]               = ovf_q;
      status[4 +: FIFO_AW+1]  = level;
   end

   always_comb begin
      ovf_d    = ovf_q;
      if (rd_acc)
         ovf_d = 1'b0;
      else if (wr_byte && full)
         ovf_d = 1'b1;
      div_d    = wr_div ? i_wb_dat[15:0] : div_q;
      rdt_d    = rd_acc ? status : rdt_q;
      wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
   end

   // Next-state logic; pop and divider relatch happen on every entry into START.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      div_l_d = div_l_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d = START;
               pop     = 1'b1;
               div_l_d = div_eff;
               cnt_d   = div_eff - 16'd1;
            end
         end
         START: begin
            if (expire) begin
               state_d = DATA;
               bit_d   = 3'd0;
               cnt_d   = div_l_q - 16'd1;
            end else begin
               cnt_d   = cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (expire) begin
               cnt_d = div_l_q - 16'd1;
               if (bit_q == 3'd7) begin
`ifdef SERVANT_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`ifdef SERVANT_UART_PARITY_EN
         PARITY: begin
            if (expire) begin
               state_d = STOP;
               cnt_d   = div_l_q - 16'd1;
            end else begin
               cnt_d   = cnt_q - 16'd1;
            end
         end
`endif
         STOP: begin
            if (expire) begin
               if (!empty) begin
                  state_d = START;
                  pop     = 1'b1;
                  div_l_d = div_eff;
                  cnt_d   = div_eff - 16'd1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is derived from the state being entered so the output register has no extra lag.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:  tx_d = 1'b0;
         DATA:   tx_d = data_q[bit_d];
`ifdef SERVANT_UART_PARITY_EN
         PARITY: tx_d = ^data_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr_q[FIFO_AW-1:0]] <= i_wb_dat[7:0];
      if (pop)
         data_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cyc_q    <= 1'b0;
         ovf_q    <= 1'b0;
         div_q    <= DEFAULT_DIV;
         div_l_q  <= DEFAULT_DIV;
         cnt_q    <= 16'd0;
         bit_q    <= 3'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         tx_q     <= 1'b1;
         rdt_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= i_wb_cyc;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
         div_l_q  <= div_l_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         tx_q     <= tx_d;
         rdt_q    <= rdt_d;
      end
   end

   assign o_wb_rdt  = rdt_q;
   assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_servant_uart.sv
// Directed bench for servant_uart in its default 8N1 build: bus accesses, frame waveforms, FIFO overflow and reset.
module tb_servant_uart;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dat;
   logic        we;
   logic        cyc;
   logic [31:0] rdt;
   logic        tx;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        cap_en = 1'b0;
   logic        tx_log[$];
   logic [31:0] rd_val;

   servant_uart #(.FIFO_AW(4), .DEFAULT_DIV(16'd139)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_wb_dat  (dat),
      .i_wb_we   (we),
      .i_wb_cyc  (cyc),
      .o_wb_rdt  (rdt),
      .o_uart_tx (tx)
   );

   always #5 clk = ~clk;

   // Line sampler, one sample per clock, placed just after the falling edge.
   always begin
      @(negedge clk);
      #1;
      if (cap_en) tx_log.push_back(tx);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      cyc = 1'b0;
      we  = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   // Request cycle, ack cycle, then cyc drops; returns on the negedge after the ack edge.
   task automatic wb_write(input logic [31:0] d);
      @(negedge clk);
      cyc = 1'b1; we = 1'b1; dat = d;
      @(negedge clk);
      @(negedge clk);
      cyc = 1'b0; we = 1'b0;
      $display("write 0x%08h", d);
   endtask

   task automatic wb_read(output logic [31:0] r);
      @(negedge clk);
      cyc = 1'b1; we = 1'b0;
      @(negedge clk);
      r = rdt;
      @(negedge clk);
      cyc = 1'b0;
      $display("read  0x%08h", r);
   endtask

   task automatic start_cap();
      tx_log.delete();
      cap_en = 1'b1;
   endtask

   task automatic wait_cap(input int n);
      int guard;
      guard = 0;
      while (tx_log.size() < n && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      cap_en = 1'b0;
      if (tx_log.size() < n) check_eq("cap_timeout", tx_log.size(), n);
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int div, input int k);
      if (k < div)          return 1'b0;
      else if (k < 9 * div) return b[(k - div) / div];
      else                  return 1'b1;
   endfunction

   task automatic check_frame(input string tag, input logic [7:0] b, input int div, input int base);
      for (int k = 0; k < 10 * div; k++)
         check_eq($sformatf("%s_tx%0d", tag, k), tx_log[base + k], frame_bit(b, div, k));
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; we = 1'b0; dat = 32'd0;

      // Reset defaults
      repeat (2) @(negedge clk);
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_rdt", rdt, 32'd0);
      rst = 1'b0;
      wb_read(rd_val);
      check_eq("rst_status", rd_val, 32'h4);
      check_eq("rst_tx_after", tx, 1'b1);

      // Single byte, div=4
      wb_write(32'h8000_0004);
      wb_write(32'h0000_0055);
      start_cap();
      wb_read(rd_val);
      check_eq("single_busy", rd_val, 32'h5);
      wait_cap(44);
      check_frame("single", 8'h55, 4, 0);
      for (int k = 40; k < 44; k++) check_eq($sformatf("single_idle%0d", k), tx_log[k], 1'b1);
      wb_read(rd_val);
      check_eq("single_done", rd_val, 32'h4);

      // Two-cycle cyc pushes exactly one byte
      do_reset(2);
      wb_write(32'h8000_0064);
      wb_write(32'h0000_0011);
      wb_write(32'h0000_0022);
      wb_read(rd_val);
      check_eq("cyc2_level", rd_val, 32'h11);

      // Overflow: one in flight, 16 queued, one dropped
      do_reset(2);
      wb_write(32'h8000_0064);
      for (int i = 0; i < 18; i++) wb_write(32'h0000_0040 + i);
      wb_read(rd_val);
      check_eq("ovf_first", rd_val, 32'h10B);
      wb_read(rd_val);
      check_eq("ovf_second", rd_val, 32'h103);

      // Back-to-back frames, divider change applies at frame 2
      do_reset(2);
      wb_write(32'h8000_0004);
      wb_write(32'h0000_00A5);
      start_cap();
      wb_write(32'h8000_0006);
      wb_write(32'h0000_003C);
      wait_cap(110);
      check_frame("b2b1", 8'hA5, 4, 0);
      check_frame("b2b2", 8'h3C, 6, 40);
      for (int k = 100; k < 110; k++) check_eq($sformatf("b2b_idle%0d", k), tx_log[k], 1'b1);

      // Divider below 2 is clamped to 2
      do_reset(2);
      wb_write(32'h8000_0001);
      wb_write(32'h0000_00F0);
      start_cap();
      wait_cap(24);
      check_frame("clamp", 8'hF0, 2, 0);
      for (int k = 20; k < 24; k++) check_eq($sformatf("clamp_idle%0d", k), tx_log[k], 1'b1);

      // Mid-frame reset during DATA with a second byte queued
      do_reset(2);
      wb_write(32'h8000_0004);
      wb_write(32'h0000_0000);
      wb_write(32'h0000_0000);
      repeat (8) @(negedge clk);
      check_eq("mid_pre_tx", tx, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_tx", tx, 1'b1);
      rst = 1'b0;
      start_cap();
      wait_cap(60);
      begin
         int zeros;
         zeros = 0;
         for (int k = 0; k < 60; k++) if (tx_log[k] == 1'b0) zeros++;
         check_eq("mid_no_frames", zeros, 0);
      end
      wb_read(rd_val);
      check_eq("mid_status", rd_val, 32'h4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
